// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock, downstream back-pressure,
// flush kill and saturating stall/bubble performance counters.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [11:0]     id_ctrl,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_b5,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [11:0]     ex_ctrl,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7_b5,
  output logic [15:0]     stall_cnt,
  output logic [15:0]     bubble_cnt
);

  typedef struct packed {
    logic [11:0]     ctrl;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7_b5;
  } ex_t;

  localparam logic [0:0] RUN       = 1'b0;
  localparam logic [0:0] LU_BUBBLE = 1'b1;

  ex_t        ex_q, id_d;
  logic [0:0] state, state_nxt;
  logic       load_use, bubble;

  // Both sources are compared even for formats that don't read rs2.
  assign load_use = ex_valid & ex_q.ctrl[9] & (ex_q.rd != 5'd0) & id_valid &
                    ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
  assign id_stall = rst_n & (load_use | ~ex_ready) & ~flush;
  assign bubble   = flush | (ex_ready & load_use);

  always_comb begin
    id_d           = '0;
    id_d.ctrl      = id_valid ? id_ctrl : 12'h000;
    id_d.pc        = id_pc;
    id_d.rs1_data  = id_rs1_data;
    id_d.rs2_data  = id_rs2_data;
    id_d.imm       = id_imm;
    id_d.rs1       = id_rs1;
    id_d.rs2       = id_rs2;
    id_d.rd        = id_rd;
    id_d.funct3    = id_funct3;
    id_d.funct7_b5 = id_funct7_b5;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
    end else if (bubble) begin
      ex_valid  <= 1'b0;
      ex_q.ctrl <= 12'h000;
    end else if (ex_ready) begin
      ex_valid <= id_valid;
      ex_q     <= id_d;
    end
  end

  always_comb begin
    state_nxt = RUN;
    if (!flush && state == RUN && ex_ready && load_use)
      state_nxt = LU_BUBBLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (id_stall && stall_cnt != 16'hFFFF)  stall_cnt  <= stall_cnt + 16'd1;
      if (bubble && bubble_cnt != 16'hFFFF)   bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

  assign ex_ctrl      = ex_q.ctrl;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1_data  = ex_q.rs1_data;
  assign ex_rs2_data  = ex_q.rs2_data;
  assign ex_imm       = ex_q.imm;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_funct3    = ex_q.funct3;
  assign ex_funct7_b5 = ex_q.funct7_b5;

`ifndef SYNTHESIS
  // The load has left EX once the bubble is in, so no hazard can recur here.
  a_no_second_hazard: assert property (@(posedge clk) disable iff (!rst_n)
    (state == LU_BUBBLE) |-> !load_use);
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: stimulus pushes expected EX payloads into a
// queue; a negedge monitor pops and compares whenever an instruction leaves EX.
module tb_id_ex_stage;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [11:0]     ctrl;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7_b5;
  } ins_t;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            id_valid = 1'b0, flush = 1'b0, ex_ready = 1'b0;
  logic [11:0]     id_ctrl = '0;
  logic [XLEN-1:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  logic [4:0]      id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [2:0]      id_funct3 = '0;
  logic            id_funct7_b5 = 1'b0;
  logic            id_stall, ex_valid, ex_funct7_b5;
  logic [11:0]     ex_ctrl;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [2:0]      ex_funct3;
  logic [15:0]     stall_cnt, bubble_cnt;

  int   checks = 0, errors = 0;
  ins_t q[$];
  ins_t mon_act, mon_exp;
  ins_t i0, i1, i2, i3, i4, i5, i6, i7, i8, i9, i10;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7_b5(id_funct7_b5), .flush(flush),
    .ex_ready(ex_ready), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7_b5(ex_funct7_b5), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic ins_t mk(logic [11:0] c, logic [31:0] pc,
                              logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd);
    ins_t r;
    r.ctrl      = c;
    r.pc        = pc;
    r.rs1_data  = pc + 32'h1000;
    r.rs2_data  = pc + 32'h2000;
    r.imm       = pc ^ 32'hFFFF_0000;
    r.rs1       = rs1;
    r.rs2       = rs2;
    r.rd        = rd;
    r.funct3    = pc[4:2];
    r.funct7_b5 = pc[2];
    return r;
  endfunction

  task automatic issue(input ins_t i);
    id_valid = 1'b1;  id_ctrl = i.ctrl;  id_pc = i.pc;
    id_rs1_data = i.rs1_data;  id_rs2_data = i.rs2_data;  id_imm = i.imm;
    id_rs1 = i.rs1;  id_rs2 = i.rs2;  id_rd = i.rd;
    id_funct3 = i.funct3;  id_funct7_b5 = i.funct7_b5;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // An instruction leaves EX when it is consumed (ex_ready) or killed by flush.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ex_valid && (ex_ready || flush)) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty act_pc=%h act_ctrl=%h", ex_pc, ex_ctrl);
        end else begin
          mon_exp = q.pop_front();
          mon_act = {ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                     ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7_b5};
          if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL ex_payload act=%h exp=%h", mon_act, mon_exp);
          end
        end
      end else if (!ex_valid) begin
        checks++;
        if (ex_ctrl !== 12'h000) begin
          errors++;
          $display("FAIL invalid_slot_ctrl act=%h exp=000", ex_ctrl);
        end
      end
    end
  end

  initial begin
    // reset state, with back-pressure asserted to exercise stall gating
    repeat (2) @(posedge clk);
    #1;
    chk("rst_id_stall", id_stall, 0);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_ctrl", ex_ctrl, 0);
    chk("rst_ex_pc", ex_pc, 0);
    chk("rst_ex_rd", ex_rd, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_bubble_cnt", bubble_cnt, 0);
    ex_ready = 1'b1;
    #2 rst_n = 1'b1;

    // plain advance
    i0 = mk(12'h819, 32'h100, 5'd1, 5'd2, 5'd5);
    issue(i0); q.push_back(i0); tick();
    chk("adv_ex_valid", ex_valid, 1);
    chk("adv_ex_ctrl", ex_ctrl, 32'h819);
    chk("adv_ex_rd", ex_rd, 5);
    chk("adv_ex_pc", ex_pc, 32'h100);

    // load-use on rs2 (load: reg_write|mem_to_reg|mem_read)
    i1 = mk(12'hE10, 32'h104, 5'd1, 5'd3, 5'd7);
    issue(i1); q.push_back(i1); tick();
    i2 = mk(12'h810, 32'h108, 5'd6, 5'd7, 5'd8);
    issue(i2); q.push_back(i2); #1;
    chk("lu_id_stall", id_stall, 1);
    tick();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_ctrl", ex_ctrl, 0);
    chk("lu_stall_released", id_stall, 0);
    chk("lu_state_bubble", dut.state, 1);
    tick();
    chk("lu_dep_valid", ex_valid, 1);
    chk("lu_dep_rd", ex_rd, 8);
    chk("lu_dep_pc", ex_pc, 32'h108);
    chk("lu_state_run", dut.state, 0);
    chk("lu_bubble_cnt", bubble_cnt, 1);
    chk("lu_stall_cnt", stall_cnt, 1);

    // load to x0 never interlocks
    i3 = mk(12'hE10, 32'h10C, 5'd2, 5'd4, 5'd0);
    issue(i3); q.push_back(i3); tick();
    i4 = mk(12'h819, 32'h110, 5'd0, 5'd0, 5'd9);
    issue(i4); q.push_back(i4); #1;
    chk("x0_no_stall", id_stall, 0);
    tick();
    chk("x0_adv_valid", ex_valid, 1);
    chk("x0_adv_pc", ex_pc, 32'h110);
    chk("x0_stall_cnt", stall_cnt, 1);

    // downstream hold for 3 cycles
    i5 = mk(12'h819, 32'h114, 5'd9, 5'd3, 5'd10);
    issue(i5); ex_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_id_stall", id_stall, 1);
      tick();
      chk("hold_ex_pc", ex_pc, 32'h110);
      chk("hold_ex_valid", ex_valid, 1);
    end
    chk("hold_stall_cnt", stall_cnt, 4);
    ex_ready = 1'b1; q.push_back(i5); tick();
    chk("hold_release_pc", ex_pc, 32'h114);

    // flush beats load-use and back-pressure together
    i6 = mk(12'hE10, 32'h118, 5'd1, 5'd2, 5'd11);
    issue(i6); q.push_back(i6); tick();
    i7 = mk(12'h819, 32'h11C, 5'd11, 5'd0, 5'd12);
    issue(i7); ex_ready = 1'b0; flush = 1'b1; #1;
    chk("flush_id_stall", id_stall, 0);
    tick();
    flush = 1'b0; ex_ready = 1'b1; id_valid = 1'b0; id_ctrl = 12'hFFF;
    chk("flush_ex_valid", ex_valid, 0);
    chk("flush_ex_ctrl", ex_ctrl, 0);
    chk("flush_bubble_cnt", bubble_cnt, 2);
    chk("flush_stall_cnt", stall_cnt, 4);
    chk("flush_state", dut.state, 0);

    // invalid slot advances with ctrl masked
    tick();
    chk("inv_ex_valid", ex_valid, 0);
    chk("inv_ex_ctrl", ex_ctrl, 0);

    // async reset while in the load-use bubble
    i8 = mk(12'hE10, 32'h120, 5'd1, 5'd2, 5'd13);
    issue(i8); q.push_back(i8); tick();
    i9 = mk(12'h819, 32'h124, 5'd5, 5'd13, 5'd14);
    issue(i9); #1;
    chk("rst2_pre_stall", id_stall, 1);
    tick();
    chk("rst2_state_bubble", dut.state, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_ex_valid", ex_valid, 0);
    chk("rst2_ex_pc", ex_pc, 0);
    chk("rst2_ex_rd", ex_rd, 0);
    chk("rst2_ex_ctrl", ex_ctrl, 0);
    chk("rst2_stall_cnt", stall_cnt, 0);
    chk("rst2_bubble_cnt", bubble_cnt, 0);
    chk("rst2_state", dut.state, 0);
    chk("rst2_queue_drained", q.size(), 0);
    q.delete();
    id_valid = 1'b0; ex_ready = 1'b0; #1;
    chk("rst2_id_stall", id_stall, 0);

    // stall counter saturation
    @(negedge clk);
    rst_n = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_pre", stall_cnt, 32'hFFFE);
    repeat (3) tick();
    chk("sat_stall_cnt", stall_cnt, 32'hFFFF);
    chk("sat_bubble_cnt", bubble_cnt, 0);

    // post-reset traffic still flows
    ex_ready = 1'b1;
    i10 = mk(12'h819, 32'h200, 5'd3, 5'd4, 5'd15);
    issue(i10); q.push_back(i10); tick();
    chk("post_ex_pc", ex_pc, 32'h200);
    id_valid = 1'b0; tick(); tick();
    chk("end_queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
